// File: rtl/scr1_tcm_arb_pkg.sv
// Shared memory-interface types and constants for the single-port TCM arbiter.
// Holds the core memif enums, the bus widths and the default starvation limit.
package scr1_tcm_arb_pkg;

  localparam int SCR1_IMEM_AWIDTH = 32;
  localparam int SCR1_IMEM_DWIDTH = 32;
  localparam int SCR1_DMEM_AWIDTH = 32;
  localparam int SCR1_DMEM_DWIDTH = 32;

  localparam int unsigned SCR1_TCM_ARB_STARVE_LIMIT_DFLT = 4;
  localparam int          SCR1_TCM_ARB_CNT_W             = 4;

  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'b00,
    SCR1_MEM_WIDTH_HWORD = 2'b01,
    SCR1_MEM_WIDTH_WORD  = 2'b10
  } type_scr1_mem_width_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;

  // Halfwords must sit on even bytes, words on 4-byte boundaries.
  function automatic logic scr1_tcm_arb_misaligned(input type_scr1_mem_width_e width,
                                                   input logic [1:0]           lsb);
    return ((width == SCR1_MEM_WIDTH_HWORD) && lsb[0]) ||
           ((width == SCR1_MEM_WIDTH_WORD)  && (lsb != 2'b00));
  endfunction

endpackage

// File: rtl/scr1_tcm_arb_starve_cnt.sv
// Saturating count of consecutive cycles a requester was held off.
// Cleared whenever the requester is granted or drops its request.
module scr1_tcm_arb_starve_cnt
  import scr1_tcm_arb_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req,
  input  logic                          grant,
  output logic [SCR1_TCM_ARB_CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (req && !grant) begin
      if (cnt != '1) cnt <= cnt + 1'b1;
    end else begin
      cnt <= '0;
    end
  end

endmodule

// File: rtl/scr1_tcm_arb.sv
// Shares one single-port byte-enabled TCM SRAM between the imem and dmem ports,
// with starvation-protected arbitration, lane steering and 1-cycle responses.
module scr1_tcm_arb
  import scr1_tcm_arb_pkg::*;
#(
  parameter logic [31:0] SCR1_TCM_SIZE = 32'h00010000,
  parameter int unsigned STARVE_LIMIT  = SCR1_TCM_ARB_STARVE_LIMIT_DFLT
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 imem_req,
  output logic                                 imem_req_ack,
  input  type_scr1_mem_cmd_e                   imem_cmd,
  input  logic [SCR1_IMEM_AWIDTH-1:0]          imem_addr,
  output logic [SCR1_IMEM_DWIDTH-1:0]          imem_rdata,
  output type_scr1_mem_resp_e                  imem_resp,
  input  logic                                 dmem_req,
  output logic                                 dmem_req_ack,
  input  type_scr1_mem_cmd_e                   dmem_cmd,
  input  type_scr1_mem_width_e                 dmem_width,
  input  logic [SCR1_DMEM_AWIDTH-1:0]          dmem_addr,
  input  logic [SCR1_DMEM_DWIDTH-1:0]          dmem_wdata,
  output logic [SCR1_DMEM_DWIDTH-1:0]          dmem_rdata,
  output type_scr1_mem_resp_e                  dmem_resp,
  output logic                                 sram_en,
  output logic                                 sram_we,
  output logic [3:0]                           sram_be,
  output logic [$clog2(SCR1_TCM_SIZE)-3:0]     sram_addr,
  output logic [31:0]                          sram_wdata,
  input  logic [31:0]                          sram_rdata
);

  localparam int                          TCM_AW     = $clog2(SCR1_TCM_SIZE);
  localparam logic [SCR1_TCM_ARB_CNT_W-1:0] STARVE_CNT = SCR1_TCM_ARB_CNT_W'(STARVE_LIMIT);

  logic [SCR1_TCM_ARB_CNT_W-1:0] imem_wait_cnt;
  logic [SCR1_TCM_ARB_CNT_W-1:0] dmem_wait_cnt;
  logic                          imem_gnt;
  logic                          dmem_gnt;
  logic                          imem_err;
  logic                          dmem_err;
  logic [3:0]                    dmem_be;
  logic [1:0]                    dmem_off_q;
  logic                          unused_imem_lsb;

  assign unused_imem_lsb = ^imem_addr[1:0];

  scr1_tcm_arb_starve_cnt i_imem_starve (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (imem_req),
    .grant (imem_gnt),
    .cnt   (imem_wait_cnt)
  );

  scr1_tcm_arb_starve_cnt i_dmem_starve (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (dmem_req),
    .grant (dmem_gnt),
    .cnt   (dmem_wait_cnt)
  );

  // dmem normally wins; a starved dmem is honoured before a starved imem.
  // rst_n gating drops the strobe immediately when reset asserts mid-access.
  always_comb begin
    imem_gnt = 1'b0;
    dmem_gnt = 1'b0;
    if (rst_n) begin
      if (imem_req && dmem_req) begin
        if (dmem_wait_cnt >= STARVE_CNT)      dmem_gnt = 1'b1;
        else if (imem_wait_cnt >= STARVE_CNT) imem_gnt = 1'b1;
        else                                  dmem_gnt = 1'b1;
      end else begin
        imem_gnt = imem_req;
        dmem_gnt = dmem_req;
      end
    end
  end

  assign imem_req_ack = imem_gnt;
  assign dmem_req_ack = dmem_gnt;

  assign imem_err = (imem_addr >= SCR1_TCM_SIZE) || (imem_cmd == SCR1_MEM_CMD_WR);
  assign dmem_err = (dmem_addr >= SCR1_TCM_SIZE) ||
                    scr1_tcm_arb_misaligned(dmem_width, dmem_addr[1:0]);

  always_comb begin
    sram_wdata = dmem_wdata;
    dmem_be    = 4'b1111;
    case (dmem_width)
      SCR1_MEM_WIDTH_BYTE: begin
        sram_wdata = {4{dmem_wdata[7:0]}};
        dmem_be    = 4'b0001 << dmem_addr[1:0];
      end
      SCR1_MEM_WIDTH_HWORD: begin
        sram_wdata = {2{dmem_wdata[15:0]}};
        dmem_be    = 4'b0011 << {dmem_addr[1], 1'b0};
      end
      default: begin
        sram_wdata = dmem_wdata;
        dmem_be    = 4'b1111;
      end
    endcase
  end

  // Erroring requests are acknowledged but never reach the macro.
  always_comb begin
    sram_en   = 1'b0;
    sram_we   = 1'b0;
    sram_be   = 4'b1111;
    sram_addr = '0;
    if (dmem_gnt) begin
      sram_en   = ~dmem_err;
      sram_we   = ~dmem_err && (dmem_cmd == SCR1_MEM_CMD_WR);
      sram_addr = dmem_addr[TCM_AW-1:2];
      if (dmem_cmd == SCR1_MEM_CMD_WR) sram_be = dmem_be;
    end else if (imem_gnt) begin
      sram_en   = ~imem_err;
      sram_addr = imem_addr[TCM_AW-1:2];
    end
  end

  // Responses follow acceptance by exactly one cycle; byte offset kept for alignment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imem_resp  <= SCR1_MEM_RESP_NOTRDY;
      dmem_resp  <= SCR1_MEM_RESP_NOTRDY;
      dmem_off_q <= 2'b00;
    end else begin
      if (imem_gnt) imem_resp <= imem_err ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
      else          imem_resp <= SCR1_MEM_RESP_NOTRDY;
      if (dmem_gnt) dmem_resp <= dmem_err ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
      else          dmem_resp <= SCR1_MEM_RESP_NOTRDY;
      if (dmem_gnt) dmem_off_q <= dmem_addr[1:0];
    end
  end

  assign imem_rdata = sram_rdata;
  assign dmem_rdata = sram_rdata >> {dmem_off_q, 3'b000};

endmodule

// File: tb/tb_scr1_tcm_arb.sv
// Self-checking bench for scr1_tcm_arb: vector table for single accesses plus
// sequences for starvation, dropped requests and reset during a response.
module tb_scr1_tcm_arb;
  import scr1_tcm_arb_pkg::*;

  localparam logic Y = 1'b1;
  localparam logic N = 1'b0;
  localparam type_scr1_mem_cmd_e   RD = SCR1_MEM_CMD_RD;
  localparam type_scr1_mem_cmd_e   WR = SCR1_MEM_CMD_WR;
  localparam type_scr1_mem_width_e B  = SCR1_MEM_WIDTH_BYTE;
  localparam type_scr1_mem_width_e H  = SCR1_MEM_WIDTH_HWORD;
  localparam type_scr1_mem_width_e W  = SCR1_MEM_WIDTH_WORD;
  localparam type_scr1_mem_resp_e  NR = SCR1_MEM_RESP_NOTRDY;
  localparam type_scr1_mem_resp_e  OK = SCR1_MEM_RESP_RDY_OK;
  localparam type_scr1_mem_resp_e  ER = SCR1_MEM_RESP_RDY_ER;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 imem_req;
  logic                 imem_req_ack;
  type_scr1_mem_cmd_e   imem_cmd;
  logic [31:0]          imem_addr;
  logic [31:0]          imem_rdata;
  type_scr1_mem_resp_e  imem_resp;
  logic                 dmem_req;
  logic                 dmem_req_ack;
  type_scr1_mem_cmd_e   dmem_cmd;
  type_scr1_mem_width_e dmem_width;
  logic [31:0]          dmem_addr;
  logic [31:0]          dmem_wdata;
  logic [31:0]          dmem_rdata;
  type_scr1_mem_resp_e  dmem_resp;
  logic                 sram_en;
  logic                 sram_we;
  logic [3:0]           sram_be;
  logic [13:0]          sram_addr;
  logic [31:0]          sram_wdata;
  logic [31:0]          sram_rdata;

  logic [31:0] mem [0:16383];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic ireq; type_scr1_mem_cmd_e icmd; logic [31:0] iaddr;
    logic dreq; type_scr1_mem_cmd_e dcmd; type_scr1_mem_width_e dw;
    logic [31:0] daddr; logic [31:0] dwdata;
    logic pre_en; logic [13:0] pre_idx; logic [31:0] pre_val;
    logic e_iack; logic e_dack; logic e_en; logic e_we; logic [3:0] e_be;
    logic [31:0] e_wdata; logic [13:0] e_saddr;
    type_scr1_mem_resp_e e_iresp; type_scr1_mem_resp_e e_dresp;
    logic [31:0] e_irdata; logic [31:0] e_drdata;
  } vec_t;

  typedef struct {
    type_scr1_mem_resp_e resp;
    logic [31:0]         data;
    logic                is_rd;
  } exp_t;

  vec_t vecs[$];
  exp_t iq[$];
  exp_t dq[$];

  scr1_tcm_arb dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (imem_req),
    .imem_req_ack (imem_req_ack),
    .imem_cmd     (imem_cmd),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .imem_resp    (imem_resp),
    .dmem_req     (dmem_req),
    .dmem_req_ack (dmem_req_ack),
    .dmem_cmd     (dmem_cmd),
    .dmem_width   (dmem_width),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_rdata   (dmem_rdata),
    .dmem_resp    (dmem_resp),
    .sram_en      (sram_en),
    .sram_we      (sram_we),
    .sram_be      (sram_be),
    .sram_addr    (sram_addr),
    .sram_wdata   (sram_wdata),
    .sram_rdata   (sram_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural single-port SRAM: byte-enabled write, registered read.
  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_we) begin
        for (int b = 0; b < 4; b++) begin
          if (sram_be[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
        end
      end else begin
        sram_rdata <= mem[sram_addr];
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic score(input string port, input type_scr1_mem_resp_e resp,
                       input logic [31:0] rdata, input logic have, input exp_t e);
    checks++;
    if (!have) begin
      errors++;
      $display("[TB] FAIL %s_resp unexpected: got %0d expected %0d", port, resp, NR);
    end else if (resp !== e.resp) begin
      errors++;
      $display("[TB] FAIL %s_resp: got %0d expected %0d", port, resp, e.resp);
    end else if (e.is_rd && (e.resp == OK) && (rdata !== e.data)) begin
      errors++;
      $display("[TB] FAIL %s_rdata: got %h expected %h", port, rdata, e.data);
    end
  endtask

  task automatic check_resp();
    exp_t e;
    logic have;
    have = (iq.size() > 0);
    e = '{NR, 32'h0, N};
    if (have) e = iq.pop_front();
    if (imem_resp !== NR || have) score("imem", imem_resp, imem_rdata, have, e);
    have = (dq.size() > 0);
    e = '{NR, 32'h0, N};
    if (have) e = dq.pop_front();
    if (dmem_resp !== NR || have) score("dmem", dmem_resp, dmem_rdata, have, e);
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
    check_resp();
  endtask

  task automatic drive(input logic ir, input type_scr1_mem_cmd_e ic, input logic [31:0] ia,
                       input logic dr, input type_scr1_mem_cmd_e dc,
                       input type_scr1_mem_width_e dw, input logic [31:0] da,
                       input logic [31:0] dd);
    imem_req = ir; imem_cmd = ic; imem_addr = ia;
    dmem_req = dr; dmem_cmd = dc; dmem_width = dw; dmem_addr = da; dmem_wdata = dd;
  endtask

  // Both ports request continuously; pat gives the expected winner per cycle.
  task automatic contend(input string pat, input string tag);
    for (int c = 0; c < pat.len(); c++) begin
      drive(Y, RD, 32'h100, Y, RD, W, 32'h0, 32'h0);
      #1;
      check($sformatf("%s c%0d dack", tag, c), {31'h0, dmem_req_ack}, {31'h0, pat[c] == "D"});
      check($sformatf("%s c%0d iack", tag, c), {31'h0, imem_req_ack}, {31'h0, pat[c] == "I"});
      if (pat[c] == "D") dq.push_back('{OK, 32'h12345678, Y});
      else               iq.push_back('{OK, 32'hDEADBEEF, Y});
      cycle();
    end
  endtask

  initial begin
    vec_t v;
    for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
    sram_rdata = 32'h0;

    // ireq icmd iaddr | dreq dcmd dw daddr dwdata | pre | iack dack en we be wdata saddr | iresp dresp irdata drdata
    vecs.push_back('{Y,RD,32'h100, N,RD,W,32'h0,32'h0, Y,14'h40,32'hDEADBEEF,
                     Y,N,Y,N,4'hF,32'h0,14'h40, OK,NR,32'hDEADBEEF,32'h0});
    vecs.push_back('{N,RD,32'h0, Y,WR,B,32'h3,32'h000000A5, Y,14'h0,32'h0,
                     N,Y,Y,Y,4'b1000,32'hA5A5A5A5,14'h0, NR,OK,32'h0,32'h0});
    vecs.push_back('{N,RD,32'h0, Y,RD,W,32'h0,32'h0, N,14'h0,32'h0,
                     N,Y,Y,N,4'hF,32'h0,14'h0, NR,OK,32'h0,32'hA5000000});
    vecs.push_back('{N,RD,32'h0, Y,RD,H,32'h2,32'h0, Y,14'h0,32'h12345678,
                     N,Y,Y,N,4'hF,32'h0,14'h0, NR,OK,32'h0,32'h00001234});
    vecs.push_back('{N,RD,32'h0, Y,WR,H,32'h6,32'h1234BEEF, Y,14'h1,32'h0,
                     N,Y,Y,Y,4'b1100,32'hBEEFBEEF,14'h1, NR,OK,32'h0,32'h0});
    vecs.push_back('{N,RD,32'h0, Y,RD,W,32'h4,32'h0, N,14'h0,32'h0,
                     N,Y,Y,N,4'hF,32'h0,14'h1, NR,OK,32'h0,32'hBEEF0000});
    vecs.push_back('{N,RD,32'h0, Y,RD,B,32'h9,32'h0, Y,14'h2,32'h11223344,
                     N,Y,Y,N,4'hF,32'h0,14'h2, NR,OK,32'h0,32'h00112233});
    vecs.push_back('{N,RD,32'h0, Y,WR,W,32'hFFFC,32'hCAFEF00D, N,14'h0,32'h0,
                     N,Y,Y,Y,4'hF,32'hCAFEF00D,14'h3FFF, NR,OK,32'h0,32'h0});
    vecs.push_back('{N,RD,32'h0, Y,RD,W,32'h10000,32'h0, N,14'h0,32'h0,
                     N,Y,N,N,4'hF,32'h0,14'h0, NR,ER,32'h0,32'h0});
    vecs.push_back('{Y,WR,32'h200, N,RD,W,32'h0,32'h0, N,14'h0,32'h0,
                     Y,N,N,N,4'hF,32'h0,14'h0, ER,NR,32'h0,32'h0});
    vecs.push_back('{N,RD,32'h0, Y,RD,H,32'h1,32'h0, N,14'h0,32'h0,
                     N,Y,N,N,4'hF,32'h0,14'h0, NR,ER,32'h0,32'h0});
    vecs.push_back('{N,RD,32'h0, Y,RD,W,32'h2,32'h0, N,14'h0,32'h0,
                     N,Y,N,N,4'hF,32'h0,14'h0, NR,ER,32'h0,32'h0});
    vecs.push_back('{Y,RD,32'h100, Y,RD,W,32'hFFFC,32'h0, N,14'h0,32'h0,
                     N,Y,Y,N,4'hF,32'h0,14'h3FFF, NR,OK,32'h0,32'hCAFEF00D});
    vecs.push_back('{Y,RD,32'hFFFC, N,RD,W,32'h0,32'h0, N,14'h0,32'h0,
                     Y,N,Y,N,4'hF,32'h0,14'h3FFF, OK,NR,32'hCAFEF00D,32'h0});
    vecs.push_back('{Y,RD,32'hFFFFFFFC, N,RD,W,32'h0,32'h0, N,14'h0,32'h0,
                     Y,N,N,N,4'hF,32'h0,14'h0, ER,NR,32'h0,32'h0});
    vecs.push_back('{N,RD,32'h0, Y,WR,B,32'h21,32'h1234565A, N,14'h0,32'h0,
                     N,Y,Y,Y,4'b0010,32'h5A5A5A5A,14'h8, NR,OK,32'h0,32'h0});
    vecs.push_back('{N,RD,32'h0, N,RD,W,32'h0,32'h0, N,14'h0,32'h0,
                     N,N,N,N,4'hF,32'h0,14'h0, NR,NR,32'h0,32'h0});

    // Reset state, with a request held high to prove the strobe is blocked.
    rst_n = 1'b0;
    drive(N, RD, 32'h0, Y, RD, W, 32'h0, 32'h0);
    #1;
    check("reset imem_resp", imem_resp, NR);
    check("reset dmem_resp", dmem_resp, NR);
    check("reset sram_en", {31'h0, sram_en}, 32'h0);
    check("reset dmem_ack", {31'h0, dmem_req_ack}, 32'h0);
    drive(N, RD, 32'h0, N, RD, W, 32'h0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cycle();

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      if (v.pre_en) mem[v.pre_idx] = v.pre_val;
      drive(v.ireq, v.icmd, v.iaddr, v.dreq, v.dcmd, v.dw, v.daddr, v.dwdata);
      #1;
      check($sformatf("vec%0d iack", i), {31'h0, imem_req_ack}, {31'h0, v.e_iack});
      check($sformatf("vec%0d dack", i), {31'h0, dmem_req_ack}, {31'h0, v.e_dack});
      check($sformatf("vec%0d sram_en", i), {31'h0, sram_en}, {31'h0, v.e_en});
      if (v.e_en) begin
        check($sformatf("vec%0d sram_we", i), {31'h0, sram_we}, {31'h0, v.e_we});
        check($sformatf("vec%0d sram_be", i), {28'h0, sram_be}, {28'h0, v.e_be});
        check($sformatf("vec%0d sram_addr", i), {18'h0, sram_addr}, {18'h0, v.e_saddr});
        if (v.e_we) check($sformatf("vec%0d sram_wdata", i), sram_wdata, v.e_wdata);
      end
      if (v.e_iresp != NR) iq.push_back('{v.e_iresp, v.e_irdata, v.icmd == RD});
      if (v.e_dresp != NR) dq.push_back('{v.e_dresp, v.e_drdata, v.dcmd == RD});
      cycle();
    end

    // Starvation: imem gets a slot after four consecutive denials.
    contend("DDDDIDDDDI", "starve");
    drive(N, RD, 32'h0, N, RD, W, 32'h0, 32'h0);
    cycle();

    // imem loses, then withdraws: no access and no response for it.
    contend("D", "drop");
    drive(N, RD, 32'h100, N, RD, W, 32'h0, 32'h0);
    #1;
    check("drop sram_en", {31'h0, sram_en}, 32'h0);
    cycle();
    check("drop imem_resp", imem_resp, NR);

    // Reset while a response is pending, with imem's counter built up.
    contend("DDD", "prerst");
    drive(Y, RD, 32'h100, Y, RD, W, 32'h0, 32'h0);
    #1;
    check("prerst dack", {31'h0, dmem_req_ack}, 32'h1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst dmem_resp", dmem_resp, NR);
    check("midrst imem_resp", imem_resp, NR);
    check("midrst sram_en", {31'h0, sram_en}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    contend("DDDDI", "postrst");
    drive(N, RD, 32'h0, N, RD, W, 32'h0, 32'h0);
    cycle();

    check("imem queue drained", iq.size(), 32'h0);
    check("dmem queue drained", dq.size(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/scr1_tcm_arb.md
Name: scr1_tcm_arb

Overview:
- Shares one single-port, 32-bit, byte-enabled TCM SRAM between the core instruction port (imem) and data port (dmem).
- Used in area-reduced configurations that replace the dual-port TCM.
- Sits between the core memory interfaces and the SRAM macro wrapper.
- Performs per-cycle arbitration with starvation protection, write-data lane replication, read-data alignment, and range/command error responses.

Parameters:
- SCR1_TCM_SIZE, `SCR1_IMEM_AWIDTH'h00010000: TCM size in bytes; power of two, at least 8.
- STARVE_LIMIT, 4: consecutive cycles a requester may be denied before it gets priority; range 1..15.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- imem_req  in  1  instruction request
- imem_req_ack  out  1  instruction request accepted this cycle
- imem_cmd  in  type_scr1_mem_cmd_e  RD/WR
- imem_addr  in  `SCR1_IMEM_AWIDTH  byte address
- imem_rdata  out  `SCR1_IMEM_DWIDTH  read data
- imem_resp  out  type_scr1_mem_resp_e  response
- dmem_req  in  1  data request
- dmem_req_ack  out  1  data request accepted this cycle
- dmem_cmd  in  type_scr1_mem_cmd_e  RD/WR
- dmem_width  in  type_scr1_mem_width_e  BYTE/HWORD/WORD
- dmem_addr  in  `SCR1_DMEM_AWIDTH  byte address
- dmem_wdata  in  `SCR1_DMEM_DWIDTH  write data, LSB-aligned
- dmem_rdata  out  `SCR1_DMEM_DWIDTH  read data, shifted to LSB
- dmem_resp  out  type_scr1_mem_resp_e  response
- sram_en  out  1  SRAM access strobe
- sram_we  out  1  SRAM write
- sram_be  out  4  byte enables
- sram_addr  out  $clog2(SCR1_TCM_SIZE)-2  word address
- sram_wdata  out  32  write data
- sram_rdata  in  32  SRAM read data, valid one cycle after sram_en & ~sram_we

Behaviour:
- Reset is asynchronous and active-low, on clk/rst_n.
  - imem_resp and dmem_resp go to NOTRDY.
  - Starvation counters reset to 0.
  - Response-owner registers reset to 0.
  - rdata outputs are don't-care while resp is NOTRDY.
- Arbitration is combinational, one grant per cycle.
  - If only one requester is active, it is granted.
  - If both are active, dmem wins, except when imem_wait_cnt >= STARVE_LIMIT; then imem wins.
  - dmem_wait_cnt has the symmetric rule and is checked first, so dmem wins if both counters are saturated.
- req_ack is asserted combinationally in the grant cycle only. The loser sees req_ack=0 and must hold its request.
- Wait counters:
  - Increment (saturating at 15) when the requester has req=1 and is not granted.
  - Clear when granted or when req=0.
- Error check in the grant cycle.
  - Error conditions:
    - address >= SCR1_TCM_SIZE;
    - imem_cmd == WR;
    - misaligned dmem access: HWORD with addr[0]=1, or WORD with addr[1:0]!=0.
  - On error: req_ack=1, sram_en=0, and the response next cycle is RDY_ER.
- Normal grant: sram_en=1, and sram_addr = granted addr[$clog2(SIZE)-1:2].
- dmem writes:
  - sram_we=1.
  - BYTE: wdata[7:0] replicated ×4, be = 1<<addr[1:0].
  - HWORD: wdata[15:0] replicated ×2, be = 2'b11<<{addr[1],1'b0}.
  - WORD: be = 4'b1111.
- Reads use be = 4'b1111.
- Response timing: fixed 1-cycle latency.
  - The cycle after an accepted request, that port's resp = RDY_OK (or RDY_ER); rdata is valid only in that cycle.
  - In any cycle with no accepted request on the previous cycle, resp = NOTRDY.
- dmem_rdata = sram_rdata >> (8 × registered addr[1:0]). Writes return RDY_OK with rdata don't-care.
- Back-to-back accepts on the same port give a continuous RDY_OK stream, one response per cycle.
- A request dropped by the core before ack produces no SRAM access and no response.
- Reset mid-access: an in-flight response is discarded and the SRAM strobe is deasserted asynchronously.

Decomposition:
- Reuse type_scr1_mem_cmd_e, type_scr1_mem_width_e and type_scr1_mem_resp_e from the shared memif package.
- Add SCR1_TCM_ARB_STARVE_LIMIT_DFLT to the arch description package.
- One sub-module, scr1_tcm_arb_starve_cnt (4-bit saturating wait counter), instantiated twice.
- Lane replication/alignment logic stays inline.

Test Plan:
- imem-only read of 0x100 with SRAM word 0xDEADBEEF -> ack same cycle, next cycle imem_resp=RDY_OK, imem_rdata=0xDEADBEEF.
- Both requesting continuously, STARVE_LIMIT=4 -> grant pattern D,D,D,D,I,D,D,D,D,I...; no requester waits more than 5 cycles.
- dmem BYTE write 0xA5 to 0x3 -> sram_be=4'b1000, sram_wdata=0xA5A5A5A5; WORD read of 0x0 returns 0xA5 in bits [31:24].
- dmem HWORD read at 0x2 with SRAM word 0x12345678 -> dmem_rdata[15:0]=0x1234, resp RDY_OK.
- Errors: dmem read of SCR1_TCM_SIZE, imem WR, and HWORD at 0x1 -> each sees sram_en=0 and RDY_ER next cycle.
- Assert rst_n low during a pending response -> resp goes to NOTRDY immediately; after release, the first access behaves normally with counters at 0.
